// File: rtl/tl_ul_bram_responder.sv
// tl_ul_bram_responder: TL-UL slave for a 512x32 byte-masked BRAM, one request in flight.
module tl_ul_bram_responder #(
  parameter int SOURCE_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                a_valid_i,
  output logic                a_ready_o,
  input  logic [2:0]          a_opcode_i,
  input  logic [2:0]          a_param_i,
  input  logic [1:0]          a_size_i,
  input  logic [SOURCE_W-1:0] a_source_i,
  input  logic [10:0]         a_address_i,
  input  logic [3:0]          a_mask_i,
  input  logic [31:0]         a_data_i,
  output logic                d_valid_o,
  input  logic                d_ready_i,
  output logic [2:0]          d_opcode_o,
  output logic [1:0]          d_param_o,
  output logic [1:0]          d_size_o,
  output logic [SOURCE_W-1:0] d_source_o,
  output logic                d_denied_o,
  output logic                d_corrupt_o,
  output logic [31:0]         d_data_o,
  output logic [8:0]          bram_rd_addr_o,
  input  logic [31:0]         bram_rd_data_i,
  output logic                bram_wr_en_o,
  output logic [8:0]          bram_wr_addr_o,
  output logic [31:0]         bram_wr_data_o,
  output logic [3:0]          bram_wr_bm_o
);
  typedef enum logic [1:0] {IDLE, RD, RESP} state_t;
  state_t               r_state;
  logic                 r_d_valid;
  logic [2:0]           r_d_opcode;
  logic [1:0]           r_d_size;
  logic [SOURCE_W-1:0]  r_d_source;
  logic                 r_d_denied;
  logic                 r_d_corrupt;
  logic [31:0]          r_d_data;
  logic                 w_fire;
  logic                 w_put;
  logic                 w_illegal;
  logic                 w_unused;
  assign w_unused       = &{1'b0, a_param_i, a_address_i[1:0]};
  assign a_ready_o      = (r_state == IDLE) | ((r_state == RESP) & d_ready_i);
  assign w_fire         = a_valid_i & a_ready_o;
  assign w_put          = (a_opcode_i == 3'd0) | (a_opcode_i == 3'd1);
  assign w_illegal      = !(w_put | (a_opcode_i == 3'd4)) | (a_size_i == 2'd3);
  assign bram_rd_addr_o = a_address_i[10:2];
  assign bram_wr_addr_o = a_address_i[10:2];
  assign bram_wr_data_o = a_data_i;
  assign bram_wr_bm_o   = a_mask_i;
  assign bram_wr_en_o   = w_fire & w_put & !w_illegal;
  assign d_valid_o      = r_d_valid;
  assign d_opcode_o     = r_d_opcode;
  assign d_param_o      = 2'd0;
  assign d_size_o       = r_d_size;
  assign d_source_o     = r_d_source;
  assign d_denied_o     = r_d_denied;
  assign d_corrupt_o    = r_d_corrupt;
  assign d_data_o       = r_d_data;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_d_valid   <= 1'b0;
      r_d_opcode  <= 3'd0;
      r_d_size    <= 2'd0;
      r_d_source  <= '0;
      r_d_denied  <= 1'b0;
      r_d_corrupt <= 1'b0;
      r_d_data    <= 32'd0;
    end else if (w_fire) begin
      r_d_source <= a_source_i;
      r_d_size   <= a_size_i;
      if (w_illegal) begin
        // unsupported opcodes with bit 2 set look like reads, so answer with corrupt data
        r_state     <= RESP;
        r_d_valid   <= 1'b1;
        r_d_denied  <= 1'b1;
        r_d_opcode  <= a_opcode_i[2] ? 3'd1 : 3'd0;
        r_d_corrupt <= a_opcode_i[2];
        r_d_data    <= 32'd0;
      end else if (w_put) begin
        r_state     <= RESP;
        r_d_valid   <= 1'b1;
        r_d_denied  <= 1'b0;
        r_d_opcode  <= 3'd0;
        r_d_corrupt <= 1'b0;
        r_d_data    <= 32'd0;
      end else begin
        r_state   <= RD;
        r_d_valid <= 1'b0;
      end
    end else if (r_state == RD) begin
      r_state     <= RESP;
      r_d_valid   <= 1'b1;
      r_d_opcode  <= 3'd1;
      r_d_denied  <= 1'b0;
      r_d_corrupt <= 1'b0;
      r_d_data    <= bram_rd_data_i;
    end else if ((r_state == RESP) & d_ready_i) begin
      r_state   <= IDLE;
      r_d_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tl_ul_bram_responder.sv
// tb_tl_ul_bram_responder: directed checks of the TL-UL BRAM responder with a behavioural BRAM.
module tb_tl_ul_bram_responder;
  logic        clk = 0;
  logic        rst = 1;
  logic        a_valid = 0, a_ready;
  logic [2:0]  a_opcode = 0, a_param = 0;
  logic [1:0]  a_size = 2;
  logic [3:0]  a_source = 0;
  logic [10:0] a_address = 0;
  logic [3:0]  a_mask = 0;
  logic [31:0] a_data = 0;
  logic        d_valid, d_ready = 1;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param, d_size;
  logic [3:0]  d_source;
  logic        d_denied, d_corrupt;
  logic [31:0] d_data;
  logic [8:0]  rd_addr, wr_addr;
  logic [31:0] rd_data, wr_data;
  logic        wr_en;
  logic [3:0]  wr_bm;
  logic [31:0] mem [512];
  int          n_pass = 0, n_total = 0, beats = 0;

  tl_ul_bram_responder #(.SOURCE_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_opcode_i(a_opcode), .a_param_i(a_param),
    .a_size_i(a_size), .a_source_i(a_source), .a_address_i(a_address), .a_mask_i(a_mask),
    .a_data_i(a_data),
    .d_valid_o(d_valid), .d_ready_i(d_ready), .d_opcode_o(d_opcode), .d_param_o(d_param),
    .d_size_o(d_size), .d_source_o(d_source), .d_denied_o(d_denied), .d_corrupt_o(d_corrupt),
    .d_data_o(d_data),
    .bram_rd_addr_o(rd_addr), .bram_rd_data_i(rd_data), .bram_wr_en_o(wr_en),
    .bram_wr_addr_o(wr_addr), .bram_wr_data_o(wr_data), .bram_wr_bm_o(wr_bm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (wr_bm[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
    rd_data <= mem[rd_addr];
    if (d_valid && d_ready) beats <= beats + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] sz, input logic [3:0] src,
                       input logic [10:0] addr, input logic [3:0] m, input logic [31:0] dat);
    a_valid = 1; a_opcode = op; a_size = sz; a_source = src; a_address = addr; a_mask = m; a_data = dat;
  endtask

  task automatic test_reset();
    #3;
    n_total++; if (d_valid !== 1'b0) $display("FAIL reset_dvalid got=%0b exp=0", d_valid); else n_pass++;
    n_total++; if (a_ready !== 1'b1) $display("FAIL reset_aready got=%0b exp=1", a_ready); else n_pass++;
    n_total++; if (wr_en !== 1'b0) $display("FAIL reset_wren got=%0b exp=0", wr_en); else n_pass++;
    n_total++; if ({d_opcode, d_size, d_source, d_denied, d_corrupt, d_data, d_param} !== 45'd0)
      $display("FAIL reset_dregs got=%h exp=0", {d_opcode, d_size, d_source, d_denied, d_corrupt, d_data}); else n_pass++;
    step();
    rst = 0;
  endtask

  task automatic test_put_full();
    d_ready = 1;
    drive(3'd0, 2'd2, 4'd3, 11'h010, 4'hF, 32'hDEADBEEF);
    #1;
    n_total++; if (wr_en !== 1'b1) $display("FAIL put_wren got=%0b exp=1", wr_en); else n_pass++;
    n_total++; if (wr_addr !== 9'd4) $display("FAIL put_wraddr got=%0d exp=4", wr_addr); else n_pass++;
    step();
    a_valid = 0;
    #1;
    n_total++; if (wr_en !== 1'b0) $display("FAIL put_wren_one_cycle got=%0b exp=0", wr_en); else n_pass++;
    n_total++; if ({d_valid, d_opcode, d_denied, d_source, d_size} !== {1'b1, 3'd0, 1'b0, 4'd3, 2'd2})
      $display("FAIL put_dbeat got=v%0b op%0d den%0b src%0d sz%0d exp=v1 op0 den0 src3 sz2", d_valid, d_opcode, d_denied, d_source, d_size); else n_pass++;
    step();
    n_total++; if (mem[4] !== 32'hDEADBEEF) $display("FAIL put_mem got=%h exp=deadbeef", mem[4]); else n_pass++;
  endtask

  task automatic test_partial_get();
    drive(3'd1, 2'd0, 4'd5, 11'h010, 4'h2, 32'h0000AA00);
    step();
    n_total++; if ({d_valid, d_source} !== {1'b1, 4'd5}) $display("FAIL partial_dbeat got=v%0b src%0d exp=v1 src5", d_valid, d_source); else n_pass++;
    drive(3'd4, 2'd2, 4'd6, 11'h010, 4'hF, 32'd0);
    #1;
    n_total++; if (a_ready !== 1'b1) $display("FAIL partial_b2b_aready got=%0b exp=1", a_ready); else n_pass++;
    step();
    a_valid = 0;
    n_total++; if ({d_valid, a_ready} !== 2'b00) $display("FAIL get_rd_state got=v%0b rdy%0b exp=v0 rdy0", d_valid, a_ready); else n_pass++;
    step();
    n_total++; if ({d_valid, d_opcode, d_source, d_data} !== {1'b1, 3'd1, 4'd6, 32'hDEADAAEF})
      $display("FAIL get_after_partial got=v%0b op%0d src%0d data=%h exp=v1 op1 src6 data=deadaaef", d_valid, d_opcode, d_source, d_data); else n_pass++;
    step();
  endtask

  task automatic test_get_stall();
    int b0;
    d_ready = 0;
    drive(3'd4, 2'd2, 4'd9, 11'h7FC, 4'hF, 32'd0);
    step();
    drive(3'd0, 2'd2, 4'd1, 11'h000, 4'hF, 32'h00000BAD);
    #1;
    n_total++; if ({wr_en, a_ready} !== 2'b00) $display("FAIL stall_rd_ignore got=wr%0b rdy%0b exp=wr0 rdy0", wr_en, a_ready); else n_pass++;
    a_valid = 0;
    step();
    b0 = beats;
    for (int i = 0; i < 5; i++) begin
      n_total++; if ({d_valid, a_ready, d_data, d_source} !== {1'b1, 1'b0, 32'h12345678, 4'd9})
        $display("FAIL stall_hold%0d got=v%0b rdy%0b data=%h src%0d exp=v1 rdy0 data=12345678 src9", i, d_valid, a_ready, d_data, d_source); else n_pass++;
      step();
    end
    d_ready = 1;
    step();
    step();
    n_total++; if (beats - b0 !== 1) $display("FAIL stall_beats got=%0d exp=1", beats - b0); else n_pass++;
    n_total++; if (mem[0] !== 32'd0) $display("FAIL stall_no_write got=%h exp=0", mem[0]); else n_pass++;
  endtask

  task automatic test_illegal();
    drive(3'd2, 2'd2, 4'd1, 11'h020, 4'hF, 32'h11111111);
    #1;
    n_total++; if (wr_en !== 1'b0) $display("FAIL illegal_op_wren got=%0b exp=0", wr_en); else n_pass++;
    step();
    n_total++; if ({d_valid, d_denied, d_opcode, d_corrupt, d_data, d_source} !== {1'b1, 1'b1, 3'd0, 1'b0, 32'd0, 4'd1})
      $display("FAIL illegal_op_beat got=v%0b den%0b op%0d cor%0b data=%h src%0d exp=v1 den1 op0 cor0 data=0 src1", d_valid, d_denied, d_opcode, d_corrupt, d_data, d_source); else n_pass++;
    drive(3'd4, 2'd3, 4'd2, 11'h7FC, 4'hF, 32'd0);
    #1;
    n_total++; if (wr_en !== 1'b0) $display("FAIL illegal_size_wren got=%0b exp=0", wr_en); else n_pass++;
    step();
    a_valid = 0;
    n_total++; if ({d_valid, d_denied, d_opcode, d_corrupt, d_data, d_source} !== {1'b1, 1'b1, 3'd1, 1'b1, 32'd0, 4'd2})
      $display("FAIL illegal_size_beat got=v%0b den%0b op%0d cor%0b data=%h src%0d exp=v1 den1 op1 cor1 data=0 src2", d_valid, d_denied, d_opcode, d_corrupt, d_data, d_source); else n_pass++;
    n_total++; if (mem[8] !== 32'd0) $display("FAIL illegal_no_write got=%h exp=0", mem[8]); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    int b0;
    b0 = beats;
    for (int i = 0; i < 10; i++) begin
      drive(3'd0, 2'd2, 4'(i), 11'(i * 4), 4'hF, 32'(100 + i));
      #1;
      n_total++; if ({a_ready, wr_en} !== 2'b11) $display("FAIL b2b_accept%0d got=rdy%0b wr%0b exp=rdy1 wr1", i, a_ready, wr_en); else n_pass++;
      step();
      n_total++; if ({d_valid, d_source} !== {1'b1, 4'(i)}) $display("FAIL b2b_beat%0d got=v%0b src%0d exp=v1 src%0d", i, d_valid, d_source, i); else n_pass++;
    end
    a_valid = 0;
    step();
    n_total++; if (beats - b0 !== 10) $display("FAIL b2b_beats got=%0d exp=10", beats - b0); else n_pass++;
    n_total++; if (mem[9] !== 32'd109) $display("FAIL b2b_mem got=%0d exp=109", mem[9]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int b0;
    drive(3'd0, 2'd2, 4'd7, 11'h050, 4'hF, 32'hCAFEF00D);
    step();
    a_valid = 0;
    step();
    drive(3'd4, 2'd2, 4'd8, 11'h050, 4'hF, 32'd0);
    step();
    a_valid = 0;
    b0 = beats;
    rst = 1;
    #1;
    n_total++; if ({d_valid, a_ready} !== 2'b01) $display("FAIL rst_rd_async got=v%0b rdy%0b exp=v0 rdy1", d_valid, a_ready); else n_pass++;
    step();
    step();
    rst = 0;
    step();
    n_total++; if ({d_valid, 32'(beats - b0)} !== {1'b0, 32'd0}) $display("FAIL rst_rd_nobeat got=v%0b beats%0d exp=v0 beats0", d_valid, beats - b0); else n_pass++;
    d_ready = 0;
    drive(3'd4, 2'd2, 4'd8, 11'h7FC, 4'hF, 32'd0);
    step();
    a_valid = 0;
    step();
    n_total++; if (d_valid !== 1'b1) $display("FAIL rst_resp_setup got=%0b exp=1", d_valid); else n_pass++;
    rst = 1;
    #1;
    n_total++; if ({d_valid, d_data} !== {1'b0, 32'd0}) $display("FAIL rst_resp_drop got=v%0b data=%h exp=v0 data=0", d_valid, d_data); else n_pass++;
    step();
    rst = 0;
    d_ready = 1;
    drive(3'd4, 2'd2, 4'd4, 11'h050, 4'hF, 32'd0);
    step();
    a_valid = 0;
    step();
    n_total++; if ({d_valid, d_opcode, d_source, d_data} !== {1'b1, 3'd1, 4'd4, 32'hCAFEF00D})
      $display("FAIL rst_get_after got=v%0b op%0d src%0d data=%h exp=v1 op1 src4 data=cafef00d", d_valid, d_opcode, d_source, d_data); else n_pass++;
    step();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    mem[511] = 32'h12345678;
    test_reset();
    test_put_full();
    test_partial_get();
    test_get_stall();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
